// File: rtl/l2_arbiter_pkg.sv
// l2_arbiter_pkg
//   Shared types for the three-way L2 arbiter: request/answer structs seen on
//   the L1/PTW <-> L2 interfaces, the requester index enum and a helper that
//   maps an L2 answer type to the requester that owns it.
package l2_arbiter_pkg;

    // Request kinds issued towards L2. The arbiter forwards them untouched.
    typedef enum logic [1:0] {
        L2_REQ_IREADLINE  = 2'd0,
        L2_REQ_DREADLINE  = 2'd1,
        L2_REQ_DWRITELINE = 2'd2,
        L2_REQ_PTWLOAD    = 2'd3
    } l2_req_type_e;

    // Answer kinds returned by L2. Encodings 5..7 are unused.
    typedef enum logic [2:0] {
        L2_ANS_ILINEREAD    = 3'd0,
        L2_ANS_DLINEREAD    = 3'd1,
        L2_ANS_DLINEWRITTEN = 3'd2,
        L2_ANS_DWBBWAKEUP   = 3'd3,
        L2_ANS_PTWLOAD      = 3'd4
    } l2_ans_type_e;

    typedef struct packed {
        logic         valid;
        l2_req_type_e req_type;
        logic [31:0]  addr;
        logic [31:0]  data;
    } l2arb_l2c_req_t;

    typedef struct packed {
        logic         valid;
        l2_ans_type_e ans_type;
        logic [31:0]  addr;
        logic [31:0]  data;
    } l2c_l2arb_ans_t;

    typedef enum logic [1:0] {
        L2ARB_SRC_I   = 2'd0,
        L2ARB_SRC_D   = 2'd1,
        L2ARB_SRC_PTW = 2'd2
    } l2arb_src_e;

    localparam int L2ARB_N_SRC = 3;

    typedef struct packed {
        logic       valid;
        l2arb_src_e src;
    } l2arb_route_t;

    // Owner of an answer type; valid=0 for encodings nobody owns.
    function automatic l2arb_route_t l2arb_ans_route(input l2_ans_type_e ans_type);
        l2arb_route_t r;
        r.valid = 1'b1;
        r.src   = L2ARB_SRC_I;
        case (ans_type)
            L2_ANS_ILINEREAD:    r.src = L2ARB_SRC_I;
            L2_ANS_DLINEREAD,
            L2_ANS_DLINEWRITTEN,
            L2_ANS_DWBBWAKEUP:   r.src = L2ARB_SRC_D;
            L2_ANS_PTWLOAD:      r.src = L2ARB_SRC_PTW;
            default:             r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/l2_arbiter_rr_grant.sv
// l2arb_rr_grant
//   N-input round-robin grant. The one-hot grant is combinational; the search
//   starts at the registered pointer, which moves one past the winner.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   flush_i        return the pointer to 0 on the next edge
//   req_i[N]       eligible requesters
//   update_i       allow the pointer to advance when a grant is issued
//   grant_o[N]     one-hot grant (all zero when nothing is eligible)
module l2arb_rr_grant #(
    parameter int N = 3
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         flush_i,
    input  logic [N-1:0] req_i,
    input  logic         update_i,
    output logic [N-1:0] grant_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_next;
    logic [PW-1:0] grant_idx;
    logic          found;

    // Two passes emulate the circular search: first ptr..N-1, then 0..ptr-1.
    always_comb begin
        grant_o   = '0;
        found     = 1'b0;
        grant_idx = '0;
        for (int j = 0; j < N; j++) begin
            if (!found && req_i[j] && (j >= int'(ptr))) begin
                found      = 1'b1;
                grant_o[j] = 1'b1;
                grant_idx  = PW'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!found && req_i[j] && (j < int'(ptr))) begin
                found      = 1'b1;
                grant_o[j] = 1'b1;
                grant_idx  = PW'(j);
            end
        end
    end

    assign ptr_next = (grant_idx == PW'(N - 1)) ? '0 : grant_idx + PW'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr <= '0;
        end else if (flush_i) begin
            ptr <= '0;
        end else if (update_i && found) begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/l2_arbiter.sv
// l2_arbiter
//   Arbitrates I-cache, D-cache and PTW requests round-robin into a one-entry
//   request register towards L2, limits each requester to MAX_OUTSTANDING
//   unanswered requests, and steers L2 answers back to their owner by type.
// Ports:
//   clk_i, rst_ni, flush_i           clock, async active-low reset, sync flush
//   *_l2arb_req_i / *_req_rdy_o      requester request + accept (I, D, PTW)
//   l2arb_l2c_req_o / l2c_*_req_rdy_i registered request to L2 + L2 accept
//   l2c_l2arb_ans_i / *_ans_rdy_o    answer from L2 + consume
//   l2arb_*_ans_o / *_ans_rdy_i      per-requester answer copy + ready
module l2_arbiter
    import l2_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           flush_i,
    input  l2arb_l2c_req_t l1i_l2arb_req_i,
    output logic           l2arb_l1i_req_rdy_o,
    input  l2arb_l2c_req_t l1d_l2arb_req_i,
    output logic           l2arb_l1d_req_rdy_o,
    input  l2arb_l2c_req_t ptw_l2arb_req_i,
    output logic           l2arb_ptw_req_rdy_o,
    output l2arb_l2c_req_t l2arb_l2c_req_o,
    input  logic           l2c_l2arb_req_rdy_i,
    input  l2c_l2arb_ans_t l2c_l2arb_ans_i,
    output logic           l2arb_l2c_ans_rdy_o,
    output l2c_l2arb_ans_t l2arb_l1i_ans_o,
    output l2c_l2arb_ans_t l2arb_l1d_ans_o,
    output l2c_l2arb_ans_t l2arb_ptw_ans_o,
    input  logic           l1i_l2arb_ans_rdy_i,
    input  logic           l1d_l2arb_ans_rdy_i,
    input  logic           ptw_l2arb_ans_rdy_i
);

    localparam int              CW      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_OUTSTANDING);

    l2arb_l2c_req_t              stage;
    l2arb_l2c_req_t              granted_req;
    l2arb_l2c_req_t              src_req [L2ARB_N_SRC];
    logic [L2ARB_N_SRC-1:0]      src_ans_rdy;
    logic [L2ARB_N_SRC-1:0]      eligible;
    logic [L2ARB_N_SRC-1:0]      rr_req;
    logic [L2ARB_N_SRC-1:0]      grant;
    logic [L2ARB_N_SRC-1:0]      ans_sel;
    logic [L2ARB_N_SRC-1:0]      ans_hs;
    logic [CW-1:0]               cnt [L2ARB_N_SRC];
    logic                        stage_free;
    logic                        any_grant;
    l2arb_route_t                route;

    assign src_req[0]  = l1i_l2arb_req_i;
    assign src_req[1]  = l1d_l2arb_req_i;
    assign src_req[2]  = ptw_l2arb_req_i;
    assign src_ans_rdy = {ptw_l2arb_ans_rdy_i, l1d_l2arb_ans_rdy_i, l1i_l2arb_ans_rdy_i};

    // The stage can take a new request if empty or being drained this cycle.
    assign stage_free = !stage.valid || l2c_l2arb_req_rdy_i;

    // Requesters are stalled while reset is asserted, during flush, and once
    // they have MAX_OUTSTANDING unanswered requests.
    always_comb begin
        eligible = '0;
        for (int k = 0; k < L2ARB_N_SRC; k++) begin
            eligible[k] = src_req[k].valid && (cnt[k] < MAX_CNT) && !flush_i && rst_ni;
        end
        rr_req = eligible & {L2ARB_N_SRC{stage_free}};
    end

    l2arb_rr_grant #(
        .N (L2ARB_N_SRC)
    ) u_rr_grant (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .flush_i  (flush_i),
        .req_i    (rr_req),
        .update_i (stage_free),
        .grant_o  (grant)
    );

    assign l2arb_l1i_req_rdy_o = grant[0];
    assign l2arb_l1d_req_rdy_o = grant[1];
    assign l2arb_ptw_req_rdy_o = grant[2];

    always_comb begin
        granted_req = '0;
        for (int k = 0; k < L2ARB_N_SRC; k++) begin
            if (grant[k]) begin
                granted_req = src_req[k];
            end
        end
        any_grant = |grant;
    end

    // Request stage: refill on grant, otherwise empty out once L2 has it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage <= '0;
        end else if (flush_i) begin
            stage <= '0;
        end else if (any_grant) begin
            stage <= granted_req;
        end else if (stage_free) begin
            stage.valid <= 1'b0;
        end
    end

    assign l2arb_l2c_req_o = stage;

    // Answer steering is purely combinational and never looks at the
    // request-side ready, so there is no path from it to the answer outputs.
    assign route = l2arb_ans_route(l2c_l2arb_ans_i.ans_type);

    always_comb begin
        ans_sel = '0;
        for (int k = 0; k < L2ARB_N_SRC; k++) begin
            ans_sel[k] = l2c_l2arb_ans_i.valid && route.valid && !flush_i
                         && (int'(route.src) == k);
        end
        ans_hs = ans_sel & src_ans_rdy;
    end

    // Unowned answer types and answers during flush are swallowed.
    always_comb begin
        l2arb_l2c_ans_rdy_o = 1'b1;
        if (!flush_i && route.valid) begin
            l2arb_l2c_ans_rdy_o = src_ans_rdy[route.src];
        end
    end

    always_comb begin
        l2arb_l1i_ans_o       = l2c_l2arb_ans_i;
        l2arb_l1i_ans_o.valid = ans_sel[0];
        l2arb_l1d_ans_o       = l2c_l2arb_ans_i;
        l2arb_l1d_ans_o.valid = ans_sel[1];
        l2arb_ptw_ans_o       = l2c_l2arb_ans_i;
        l2arb_ptw_ans_o.valid = ans_sel[2];
    end

    // Outstanding counters: a grant and an answer in the same cycle cancel.
    // Eligibility keeps the increment below MAX; a decrement at 0 holds.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < L2ARB_N_SRC; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < L2ARB_N_SRC; k++) begin
                if (flush_i) begin
                    cnt[k] <= '0;
                end else if (grant[k] && !ans_hs[k]) begin
                    cnt[k] <= cnt[k] + CW'(1);
                end else if (!grant[k] && ans_hs[k] && (cnt[k] != '0)) begin
                    cnt[k] <= cnt[k] - CW'(1);
                end
            end
        end
    end

    for (genvar k = 0; k < L2ARB_N_SRC; k++) begin : g_cnt_chk
        cnt_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
            !(ans_hs[k] && !grant[k] && (cnt[k] == '0)));
    end

endmodule

// File: tb/tb_l2_arbiter.sv
// tb_l2_arbiter
//   Self-checking bench for l2_arbiter: a table of combinational answer
//   steering vectors plus hand-written request/answer/flush sequences. Every
//   accepted request is queued as an expectation and compared when L2 takes it.
module tb_l2_arbiter;
    import l2_arbiter_pkg::*;

    logic           clk_i     = 1'b0;
    logic           rst_ni    = 1'b0;
    logic           flush_i   = 1'b0;
    l2arb_l2c_req_t i_req     = '0;
    l2arb_l2c_req_t d_req     = '0;
    l2arb_l2c_req_t p_req     = '0;
    logic           i_rdy;
    logic           d_rdy;
    logic           p_rdy;
    l2arb_l2c_req_t l2_req;
    logic           l2_rdy    = 1'b1;
    l2c_l2arb_ans_t l2_ans    = '0;
    logic           ans_rdy;
    l2c_l2arb_ans_t i_ans;
    l2c_l2arb_ans_t d_ans;
    l2c_l2arb_ans_t p_ans;
    logic           i_ans_rdy = 1'b0;
    logic           d_ans_rdy = 1'b0;
    logic           p_ans_rdy = 1'b0;

    int             checks = 0;
    int             errors = 0;
    int             seq_no [3];
    l2arb_l2c_req_t exp_q [$];
    l2arb_l2c_req_t held;

    typedef struct {
        l2_ans_type_e t;
        logic         v;
        logic         fl;
        logic [2:0]   prdy;
        logic [3:0]   exp;
    } vec_t;

    vec_t vecs [12];

    l2_arbiter #(
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .flush_i             (flush_i),
        .l1i_l2arb_req_i     (i_req),
        .l2arb_l1i_req_rdy_o (i_rdy),
        .l1d_l2arb_req_i     (d_req),
        .l2arb_l1d_req_rdy_o (d_rdy),
        .ptw_l2arb_req_i     (p_req),
        .l2arb_ptw_req_rdy_o (p_rdy),
        .l2arb_l2c_req_o     (l2_req),
        .l2c_l2arb_req_rdy_i (l2_rdy),
        .l2c_l2arb_ans_i     (l2_ans),
        .l2arb_l2c_ans_rdy_o (ans_rdy),
        .l2arb_l1i_ans_o     (i_ans),
        .l2arb_l1d_ans_o     (d_ans),
        .l2arb_ptw_ans_o     (p_ans),
        .l1i_l2arb_ans_rdy_i (i_ans_rdy),
        .l1d_l2arb_ans_rdy_i (d_ans_rdy),
        .ptw_l2arb_ans_rdy_i (p_ans_rdy)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    function automatic l2arb_l2c_req_t make_req(input int src, input int n);
        l2arb_l2c_req_t r;
        logic [31:0]    nn;
        nn         = 32'(n);
        r.valid    = 1'b1;
        r.req_type = L2_REQ_PTWLOAD;
        if (src == 0) r.req_type = L2_REQ_IREADLINE;
        if (src == 1) r.req_type = nn[0] ? L2_REQ_DWRITELINE : L2_REQ_DREADLINE;
        r.addr     = {4'(src), nn[27:0]};
        r.data     = ~r.addr;
        return r;
    endfunction

    function automatic l2arb_l2c_req_t get_req(input int src);
        if (src == 0) return i_req;
        if (src == 1) return d_req;
        return p_req;
    endfunction

    function automatic logic [2:0] rdy_vec();
        return {p_rdy, d_rdy, i_rdy};
    endfunction

    task automatic set_req(input int src, input logic v);
        l2arb_l2c_req_t r;
        r       = make_req(src, seq_no[src]);
        r.valid = v;
        case (src)
            0:       i_req = r;
            1:       d_req = r;
            default: p_req = r;
        endcase
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    // One cycle with the expected one-hot grant; the granted request becomes
    // an expectation and the requester moves on to its next request.
    task automatic grant_step(input string name, input logic [2:0] exp_vec);
        l2arb_l2c_req_t r;
        @(negedge clk_i);
        check_output(name, 128'(rdy_vec()), 128'(exp_vec));
        for (int s = 0; s < 3; s++) begin
            if (exp_vec[s]) exp_q.push_back(get_req(s));
        end
        next_cycle();
        for (int s = 0; s < 3; s++) begin
            if (exp_vec[s]) begin
                r = get_req(s);
                seq_no[s]++;
                set_req(s, r.valid);
            end
        end
    endtask

    // Only one requester asks; counts how many requests get in before the
    // outstanding limit closes the door.
    task automatic flood(input string name, input int src, input int exp_n);
        int   got;
        logic took;
        got = 0;
        set_req(src, 1'b1);
        for (int c = 0; c < exp_n + 3; c++) begin
            @(negedge clk_i);
            took = (rdy_vec() >> src) & 3'b001;
            if (took) begin
                exp_q.push_back(get_req(src));
                got++;
            end
            next_cycle();
            if (took) begin
                seq_no[src]++;
                set_req(src, 1'b1);
            end
        end
        set_req(src, 1'b0);
        check_output(name, 128'(got), 128'(exp_n));
        next_cycle();
    endtask

    // Combinational steering vector applied between clock edges only, so no
    // answer handshake ever reaches a clock edge.
    task automatic apply_stimulus(input vec_t v, input int idx);
        @(posedge clk_i);
        #1;
        l2_ans.valid    = v.v;
        l2_ans.ans_type = v.t;
        l2_ans.addr     = 32'h0000_1000 + 32'(idx);
        l2_ans.data     = 32'hD00D_0000 + 32'(idx);
        flush_i         = v.fl;
        {p_ans_rdy, d_ans_rdy, i_ans_rdy} = v.prdy;
        #3;
        check_output($sformatf("steer[%0d]", idx),
                     128'({p_ans.valid, d_ans.valid, i_ans.valid, ans_rdy}), 128'(v.exp));
        check_output($sformatf("steer_data[%0d]", idx),
                     128'({i_ans.data, d_ans.data, p_ans.data}), 128'({3{l2_ans.data}}));
        @(negedge clk_i);
        l2_ans.valid = 1'b0;
        flush_i      = 1'b0;
        {p_ans_rdy, d_ans_rdy, i_ans_rdy} = 3'b000;
    endtask

    // Scoreboard: whenever L2 takes the staged request, it must be the oldest
    // outstanding expectation.
    always @(negedge clk_i) begin
        if (rst_ni && l2_req.valid && l2_rdy) begin
            if (exp_q.size() == 0) begin
                check_output("l2_req_unexpected", 128'(l2_req), 128'(0));
            end else begin
                check_output("l2_req", 128'(l2_req), 128'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // {p_valid, d_valid, i_valid, ans_rdy}; prdy = {ptw, l1d, l1i}
        vecs[0]  = '{L2_ANS_ILINEREAD,    1'b1, 1'b0, 3'b001, 4'b0011};
        vecs[1]  = '{L2_ANS_ILINEREAD,    1'b1, 1'b0, 3'b110, 4'b0010};
        vecs[2]  = '{L2_ANS_DLINEREAD,    1'b1, 1'b0, 3'b010, 4'b0101};
        vecs[3]  = '{L2_ANS_DLINEWRITTEN, 1'b1, 1'b0, 3'b101, 4'b0100};
        vecs[4]  = '{L2_ANS_DWBBWAKEUP,   1'b1, 1'b0, 3'b010, 4'b0101};
        vecs[5]  = '{L2_ANS_PTWLOAD,      1'b1, 1'b0, 3'b100, 4'b1001};
        vecs[6]  = '{L2_ANS_PTWLOAD,      1'b1, 1'b0, 3'b011, 4'b1000};
        vecs[7]  = '{l2_ans_type_e'(3'd5), 1'b1, 1'b0, 3'b000, 4'b0001};
        vecs[8]  = '{l2_ans_type_e'(3'd7), 1'b1, 1'b0, 3'b000, 4'b0001};
        vecs[9]  = '{L2_ANS_DLINEREAD,    1'b0, 1'b0, 3'b101, 4'b0000};
        vecs[10] = '{L2_ANS_PTWLOAD,      1'b1, 1'b1, 3'b000, 4'b0001};
        vecs[11] = '{L2_ANS_ILINEREAD,    1'b1, 1'b1, 3'b000, 4'b0001};

        for (int s = 0; s < 3; s++) seq_no[s] = 0;

        // Reset with all requesters already asking.
        for (int s = 0; s < 3; s++) set_req(s, 1'b1);
        repeat (2) @(negedge clk_i);
        check_output("reset_req_o", 128'(l2_req), 128'(0));
        check_output("reset_rdy", 128'(rdy_vec()), 128'(0));
        check_output("reset_ans_valid", 128'({p_ans.valid, d_ans.valid, i_ans.valid}), 128'(0));
        next_cycle();
        rst_ni = 1'b1;

        // Round robin with L2 always ready: I, D, PTW, I, D, PTW.
        for (int n = 0; n < 6; n++) begin
            grant_step($sformatf("rr_grant[%0d]", n), 3'b001 << (n % 3));
            check_output("rr_req_valid", 128'(l2_req.valid), 128'(1));
        end
        for (int s = 0; s < 3; s++) set_req(s, 1'b0);
        next_cycle();
        check_output("rr_drained", 128'(l2_req.valid), 128'(0));

        // Outstanding now I=2, D=2, PTW=2.
        for (int i = 0; i < 12; i++) apply_stimulus(vecs[i], i);

        // Answer held while the D-cache is not ready, then consumed.
        next_cycle();
        l2_ans.valid    = 1'b1;
        l2_ans.ans_type = L2_ANS_DWBBWAKEUP;
        l2_ans.addr     = 32'hABCD_0000;
        d_ans_rdy       = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            check_output("ans_hold", 128'({p_ans.valid, d_ans.valid, i_ans.valid, ans_rdy}), 128'(4'b0100));
            next_cycle();
        end
        d_ans_rdy = 1'b1;
        @(negedge clk_i);
        check_output("ans_release", 128'({p_ans.valid, d_ans.valid, i_ans.valid, ans_rdy}), 128'(4'b0101));
        next_cycle();
        l2_ans.valid = 1'b0;
        d_ans_rdy    = 1'b0;

        // D grant and D answer handshake in the same cycle: D stays at 1.
        set_req(1, 1'b1);
        l2_ans.valid    = 1'b1;
        l2_ans.ans_type = L2_ANS_DLINEREAD;
        d_ans_rdy       = 1'b1;
        grant_step("same_cycle_grant", 3'b010);
        l2_ans.valid = 1'b0;
        d_ans_rdy    = 1'b0;
        set_req(1, 1'b0);
        next_cycle();

        flood("flood_d_after_ans", 1, 3);
        flood("flood_i", 0, 2);

        // PTW limit: fill to 4, stays closed, one answer reopens it next cycle.
        flood("ptw_fill", 2, 2);
        set_req(2, 1'b1);
        repeat (2) begin
            @(negedge clk_i);
            check_output("ptw_capped", 128'(p_rdy), 128'(0));
            next_cycle();
        end
        l2_ans.valid    = 1'b1;
        l2_ans.ans_type = L2_ANS_PTWLOAD;
        p_ans_rdy       = 1'b1;
        @(negedge clk_i);
        check_output("ptw_capped_during_ans", 128'({p_rdy, ans_rdy}), 128'(2'b01));
        next_cycle();
        l2_ans.valid = 1'b0;
        p_ans_rdy    = 1'b0;
        grant_step("ptw_after_ans", 3'b100);
        set_req(2, 1'b0);
        next_cycle();

        // Clearing flush, then build outstanding {I=2, D=1, PTW=3}.
        flush_i = 1'b1;
        next_cycle();
        flush_i = 1'b0;
        set_req(0, 1'b1);
        repeat (2) grant_step("pre_i", 3'b001);
        set_req(0, 1'b0);
        set_req(2, 1'b1);
        repeat (2) grant_step("pre_p", 3'b100);
        set_req(2, 1'b0);
        next_cycle();
        l2_rdy = 1'b0;
        set_req(1, 1'b1);
        held = d_req;
        grant_step("pre_d", 3'b010);

        // L2 stalls: stage bit-identical, no grants.
        for (int s = 0; s < 3; s++) set_req(s, 1'b1);
        repeat (5) begin
            @(negedge clk_i);
            check_output("hold_rdy", 128'(rdy_vec()), 128'(0));
            check_output("hold_stage", 128'(l2_req), 128'(held));
            next_cycle();
        end
        // Pointer sat at PTW through the stall.
        l2_rdy = 1'b1;
        grant_step("hold_rr_ptr", 3'b100);
        l2_rdy = 1'b0;
        @(negedge clk_i);
        check_output("stage_full_no_grant", 128'(rdy_vec()), 128'(0));
        next_cycle();

        // Flush cycle with an answer arriving.
        flush_i         = 1'b1;
        l2_rdy          = 1'b1;
        l2_ans.valid    = 1'b1;
        l2_ans.ans_type = L2_ANS_DLINEREAD;
        d_ans_rdy       = 1'b1;
        @(negedge clk_i);
        check_output("flush_no_grant", 128'(rdy_vec()), 128'(0));
        check_output("flush_ans_drop", 128'({p_ans.valid, d_ans.valid, i_ans.valid, ans_rdy}), 128'(4'b0001));
        next_cycle();
        flush_i      = 1'b0;
        l2_ans.valid = 1'b0;
        d_ans_rdy    = 1'b0;
        l2_rdy       = 1'b0;
        check_output("flush_stage_clear", 128'(l2_req.valid), 128'(0));
        grant_step("flush_rr_ptr", 3'b001);
        for (int s = 0; s < 3; s++) set_req(s, 1'b0);
        l2_rdy = 1'b1;
        next_cycle();

        flood("flush_cnt_d", 1, 4);
        flood("flush_cnt_p", 2, 4);
        flood("flush_cnt_i", 0, 3);

        repeat (3) next_cycle();
        check_output("scoreboard_empty", 128'(exp_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
